vid_fifo_stream_out: RTL and testbench

//   Video output stage directly downstream of the 2048x32-in/16-out prefetch FIFO. Generates

---
 rtl/vid_out_pkg.sv | 45 ++++
 rtl/vid_timing_cnt.sv | 71 +++++++
 rtl/vid_fifo_stream_out.sv | 131 +++++++++++++
 tb/tb_vid_fifo_stream_out.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vid_out_pkg.sv
// Shared FSM encoding, default 720p timing and RGB565 colour-bar constants
// for the video output stage.
package vid_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } vid_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_H_ACT  = 1280;
  localparam int DEF_H_FP   = 110;
  localparam int DEF_H_SYNC = 40;
  localparam int DEF_H_BP   = 220;
  localparam int DEF_V_ACT  = 720;
  localparam int DEF_V_FP   = 5;
  localparam int DEF_V_SYNC = 5;
  localparam int DEF_V_BP   = 20;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster h/v counters (SYNC, BP, ACT, FP order) and region decode.
// Exposes h_cnt only when VID_TEST_PATTERN_EN is defined (bar index source).
module vid_timing_cnt #(
  parameter int H_ACT  = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_ACT  = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter int HW     = $clog2(H_SYNC + H_BP + H_ACT + H_FP)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
`ifdef VID_TEST_PATTERN_EN
  output logic [HW-1:0] o_h_cnt,
`endif
  output logic          o_hs_pre,
  output logic          o_vs_pre,
  output logic          o_act,
  output logic          o_sof_pre,
  output logic          o_frame_end
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BP + V_ACT);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Counters sit at 0 whenever the raster is not running.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

`ifdef VID_TEST_PATTERN_EN
  assign o_h_cnt     = r_h_cnt;
`endif
  assign o_hs_pre    = i_run && (r_h_cnt < H_SYNC_E);
  assign o_vs_pre    = i_run && (r_v_cnt < V_SYNC_E);
  assign o_act       = i_run && (r_h_cnt >= H_ACT_LO) && (r_h_cnt < H_ACT_HI)
                             && (r_v_cnt >= V_ACT_LO) && (r_v_cnt < V_ACT_HI);
  assign o_sof_pre   = i_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vid_fifo_stream_out.sv
// Video output stage: raster FSM, FIFO pop, registered HS/VS/DE/pixel, underflow flag.
// Define VID_TEST_PATTERN_EN to pad starved pixels with colour bars instead of PAD_PIX.
module vid_fifo_stream_out
  import vid_out_pkg::*;
#(
  parameter int              DATA_W  = DEF_DATA_W,
  parameter int              H_ACT   = DEF_H_ACT,
  parameter int              H_FP    = DEF_H_FP,
  parameter int              H_SYNC  = DEF_H_SYNC,
  parameter int              H_BP    = DEF_H_BP,
  parameter int              V_ACT   = DEF_V_ACT,
  parameter int              V_FP    = DEF_V_FP,
  parameter int              V_SYNC  = DEF_V_SYNC,
  parameter int              V_BP    = DEF_V_BP,
  parameter bit              HS_POL  = 1'b1,
  parameter bit              VS_POL  = 1'b1,
  parameter logic [DATA_W-1:0] PAD_PIX = '0
) (
  input  logic              i_rd_clk,
  input  logic              i_rd_rst,
  input  logic              i_vid_en,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  input  logic              i_fifo_rd_vld,
  output logic              o_fifo_rd_en,
  output logic              o_vid_hs,
  output logic              o_vid_vs,
  output logic              o_vid_de,
  output logic [DATA_W-1:0] o_vid_data,
  output logic              o_frame_sof,
  output logic              o_underflow,
  input  logic              i_underflow_clr
);

  localparam int HW = $clog2(H_SYNC + H_BP + H_ACT + H_FP);

  vid_state_t        r_state;
  vid_state_t        w_state_nxt;
  logic              w_run;
  logic              w_hs_pre;
  logic              w_vs_pre;
  logic              w_act;
  logic              w_sof_pre;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_fill;
  logic              r_vid_hs;
  logic              r_vid_vs;
  logic              r_vid_de;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_frame_sof;
  logic              r_underflow;

  assign w_run = (r_state == ST_RUN);

`ifdef VID_TEST_PATTERN_EN
  logic [HW-1:0] w_h_cnt;
  logic [HW-1:0] w_h_off;
  logic [2:0]    w_bar;
  assign w_h_off = w_h_cnt - HW'(H_SYNC + H_BP);
  assign w_bar   = 3'(w_h_off >> $clog2(H_ACT / 8));
  assign w_fill  = DATA_W'(bar_color(w_bar));
`else
  assign w_fill  = PAD_PIX;
`endif

  vid_timing_cnt #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP),
    .HW    (HW)
  ) u_timing (
    .i_clk       (i_rd_clk),
    .i_rst       (i_rd_rst),
    .i_run       (w_run),
`ifdef VID_TEST_PATTERN_EN
    .o_h_cnt     (w_h_cnt),
`endif
    .o_hs_pre    (w_hs_pre),
    .o_vs_pre    (w_vs_pre),
    .o_act       (w_act),
    .o_sof_pre   (w_sof_pre),
    .o_frame_end (w_frame_end)
  );

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // vid_en is only honoured as a stop request on the last cycle of a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_vid_en) w_state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (!i_vid_en)         w_state_nxt = ST_IDLE;
        else if (i_fifo_rd_vld) w_state_nxt = ST_RUN;
      end
      ST_RUN:   if (!i_vid_en && w_frame_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_fifo_rd_en = w_act;

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_vid_hs    <= ~HS_POL;
      r_vid_vs    <= ~VS_POL;
      r_vid_de    <= 1'b0;
      r_vid_data  <= '0;
      r_frame_sof <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_vid_hs    <= w_hs_pre ? HS_POL : ~HS_POL;
      r_vid_vs    <= w_vs_pre ? VS_POL : ~VS_POL;
      r_vid_de    <= w_act;
      r_vid_data  <= w_act ? (i_fifo_rd_vld ? i_fifo_rd_data : w_fill) : '0;
      r_frame_sof <= w_sof_pre;
      // A starved pixel on the clear cycle keeps the flag set.
      if (w_act && !i_fifo_rd_vld) r_underflow <= 1'b1;
      else if (i_underflow_clr)    r_underflow <= 1'b0;
    end
  end

  assign o_vid_hs    = r_vid_hs;
  assign o_vid_vs    = r_vid_vs;
  assign o_vid_de    = r_vid_de;
  assign o_vid_data  = r_vid_data;
  assign o_frame_sof = r_frame_sof;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_vid_fifo_stream_out.sv
// Self-checking bench for vid_fifo_stream_out on a reduced 14x7 raster.
module tb_vid_fifo_stream_out;

  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam logic [15:0] PAD = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, vid_en, vld, clr;
  logic [15:0] rdata;
  logic        rd_en, hs, vs, de, sof, uf;
  logic [15:0] vdata;

  always #5 clk = ~clk;

  vid_fifo_stream_out #(
    .DATA_W(16), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PAD_PIX(PAD)
  ) dut (
    .i_rd_clk(clk), .i_rd_rst(rst), .i_vid_en(vid_en),
    .i_fifo_rd_data(rdata), .i_fifo_rd_vld(vld), .o_fifo_rd_en(rd_en),
    .o_vid_hs(hs), .o_vid_vs(vs), .o_vid_de(de), .o_vid_data(vdata),
    .o_frame_sof(sof), .o_underflow(uf), .i_underflow_clr(clr)
  );

  int n_assert = 0, n_fail = 0;

  logic [15:0] q[$];
  logic [15:0] de_log[$];
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // Reference: mode 0=idle 1=waiting for data 2=raster; m_t = linear cycle in frame.
  int   m_mode = 0, m_t = 0;
  logic e_de = 0, e_hs = 0, e_vs = 0, e_sof = 0, e_uf = 0;
  logic [15:0] e_data = 0;
  int   starve_t = -1;
  bit   rand_gap = 0, auto_fill = 0, chk_period = 0;
  int   pops = 0, cyc = 0, hs_last = -1, vs_last = -1;
  logic hs_prev = 0, vs_prev = 0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fill_exp(input int h);
`ifdef VID_TEST_PATTERN_EN
    return bars[(h - H_SYNC - H_BP) / (H_ACT / 8)];
`else
    return PAD;
`endif
  endfunction

  task automatic drive_fifo();
    bit gap;
    if (auto_fill) while (q.size() < 40) q.push_back(16'($urandom));
    gap = (rand_gap && $urandom_range(0, 3) == 0) ||
          (starve_t >= 0 && m_mode == 2 && m_t == starve_t);
    vld   = (q.size() > 0) && !gap;
    rdata = (q.size() > 0) ? q[0] : 16'($urandom);
  endtask

  task automatic tick();
    int h, v;
    bit a, popped;
    @(negedge clk);
    h = m_t % H_TOT;
    v = m_t / H_TOT;
    a = (m_mode == 2) && h >= H_SYNC + H_BP && h < H_SYNC + H_BP + H_ACT
        && v >= V_SYNC + V_BP && v < V_SYNC + V_BP + V_ACT;
    chk(rd_en, a, "rd_en");
    chk(de, e_de, "de");
    chk(vdata, e_data, "data");
    chk(hs, e_hs, "hs");
    chk(vs, e_vs, "vs");
    chk(sof, e_sof, "sof");
    chk(uf, e_uf, "underflow");
    popped = 0;
    if (rst) begin
      m_mode = 0; m_t = 0;
      e_de = 0; e_data = 0; e_hs = 0; e_vs = 0; e_sof = 0; e_uf = 0;
    end else begin
      e_de   = a;
      e_data = a ? (vld ? rdata : fill_exp(h)) : 16'h0;
      e_hs   = (m_mode == 2) && h < H_SYNC;
      e_vs   = (m_mode == 2) && v < V_SYNC;
      e_sof  = (m_mode == 2) && m_t == 0;
      if (a && !vld) e_uf = 1;
      else if (clr)  e_uf = 0;
      popped = a && vld;
      case (m_mode)
        0: if (vid_en) m_mode = 1;
        1: if (!vid_en) m_mode = 0;
           else if (vld) begin m_mode = 2; m_t = 0; end
        default: if (m_t == F_TOT - 1) begin
                   m_t = 0;
                   if (!vid_en) m_mode = 0;
                 end else m_t++;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    if (popped) begin void'(q.pop_front()); pops++; end
    if (de) de_log.push_back(vdata);
    if (hs && !hs_prev) begin
      if (chk_period && hs_last >= 0) chk(cyc - hs_last, H_TOT, "hs_period");
      hs_last = cyc;
    end
    if (vs && !vs_prev) begin
      if (chk_period && vs_last >= 0) chk(cyc - vs_last, F_TOT, "vs_period");
      vs_last = cyc;
    end
    hs_prev = hs;
    vs_prev = vs;
    drive_fifo();
  endtask

  task automatic wait_t(input int target, input string tag);
    int n = 0;
    while (!(m_mode == 2 && m_t == target) && n < 300) begin tick(); n++; end
    chk(n < 300, 1'b1, tag);
  endtask

  initial begin
    int n;
    rst = 1; vid_en = 0; clr = 0; vld = 0; rdata = 0;
    @(posedge clk); #1;
    repeat (3) tick();
    chk(de, 0, "rst_de"); chk(hs, 0, "rst_hs"); chk(vs, 0, "rst_vs");
    chk(rd_en, 0, "rst_rd_en"); chk(uf, 0, "rst_uf"); chk(vdata, 0, "rst_data");
    rst = 0;

    // Raster must not start while the FIFO is empty.
    vid_en = 1;
    repeat (20) tick();
    chk(hs, 0, "prime_hs"); chk(vs, 0, "prime_vs");
    for (int i = 0; i < 32; i++) q.push_back(16'(i));
    pops = 0;
    drive_fifo();
    tick(); tick();
    chk(sof, 1, "sof_latency");
    repeat (94) tick();
    chk(pops, 32, "frame0_pops");
    chk(q.size(), 0, "frame0_drained");

    // Free-running random frames with HS/VS period checks.
    auto_fill = 1; chk_period = 1; hs_last = -1; vs_last = -1;
    drive_fifo();
    repeat (3 * F_TOT) tick();

    // Starve pixel 3 of active line 1 with a known word sequence.
    wait_t(0, "wait_starve_frame");
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(16'(i));
    drive_fifo();
    de_log.delete();
    starve_t = H_TOT * (V_SYNC + V_BP + 1) + H_SYNC + H_BP + 3;
    repeat (F_TOT - 1) tick();
    chk(de_log.size(), 32, "starve_de_count");
    chk(de_log[11], fill_exp(H_SYNC + H_BP + 3), "starve_fill");
    chk(de_log[12], 16'd11, "starve_next_word");
    chk(uf, 1, "starve_uf_set");
    starve_t = -1;
    clr = 1; tick(); clr = 0;
    chk(uf, 0, "uf_clr");

    // Clear held while a new underflow happens: set must win.
    wait_t(0, "wait_setwins_frame");
    clr = 1;
    starve_t = H_TOT * (V_SYNC + V_BP + 1) + H_SYNC + H_BP + 3;
    wait_t(starve_t + 1, "wait_setwins_pix");
    chk(uf, 1, "uf_set_wins");
    starve_t = -1;
    tick();
    chk(uf, 0, "uf_clr_after");
    clr = 0;

    // Random FIFO gaps: raster must not slip.
    rand_gap = 1;
    repeat (2 * F_TOT) tick();
    rand_gap = 0;
    drive_fifo();

    // Stop request mid-frame: finish the frame, then idle with no pops.
    wait_t(49, "wait_stop_point");
    vid_en = 0; pops = 0; chk_period = 0;
    n = 0;
    while (m_mode != 0 && n < 200) begin tick(); n++; end
    chk(n < 200, 1'b1, "stop_timeout");
    chk(pops, 21, "stop_tail_pops");
    repeat (20) tick();
    chk(pops, 21, "idle_no_pop");
    chk(de, 0, "idle_de");

    // Reset in the middle of a running frame.
    vid_en = 1;
    repeat (40) tick();
    rst = 1; tick(); rst = 0; vid_en = 0;
    chk(de, 0, "midrst_de"); chk(hs, 0, "midrst_hs"); chk(vs, 0, "midrst_vs");
    chk(sof, 0, "midrst_sof");
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
